npu_wb_master: RTL and testbench

Wishbone classic (B3, non-pipelined) initiator that drives the Wishbone slave port of user_proj_npu. Used for on-chip self-test and data-mover traffic.
Accepts word or incrementing-burst commands on a valid/ready command channel and takes write data on a valid/ready stream. Returns one response beat per Wishbone transfer. Includes per-transfer ack timeout with error reporting.

---
 rtl/npu_wb_pkg.sv | 25 ++
 rtl/npu_wb_timeout.sv | 27 ++
 rtl/npu_wb_master.sv | 152 +++++++++++++++
 tb/tb_npu_wb_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_wb_pkg.sv
// Shared types and bus constants for the NPU Wishbone initiator and related bus blocks.
package npu_wb_pkg;

  localparam int WB_ADR_W      = 32;
  localparam int WB_DAT_W      = 32;
  localparam int WB_SEL_W      = 4;
  localparam int CMD_LEN_MAX_W = 16;

  localparam logic [WB_ADR_W-1:0] WB_ADR_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic                     we;
    logic [WB_ADR_W-1:0]      adr;
    logic [CMD_LEN_MAX_W-1:0] len;
    logic [WB_SEL_W-1:0]      sel;
  } wb_cmd_t;

endpackage

// File: rtl/npu_wb_timeout.sv
// Ack-wait timer: counts enabled cycles and flags expiry on the TIMEOUT-th waiting cycle.
module npu_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Expiry is flagged during the last allowed waiting cycle so the strobe is high exactly TIMEOUT cycles.
  assign expired = enable && (cnt_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/npu_wb_master.sv
// Wishbone B3 classic initiator: word/incrementing-burst commands, write-data stream,
// one response beat per transfer, per-transfer ack timeout.
//
// state  | meaning
// IDLE   | waiting for a command, cyc low
// WDATA  | cyc held, waiting for this beat's write data
// STROBE | cyc/stb high, waiting for ack or timeout
// RESP   | presenting the response beat, stb low
module npu_wb_master
  import npu_wb_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_data_o,
  output logic                rsp_last_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  output logic                busy_o
);

  wb_state_e state_q, state_d;

  // cmd_q.len is decremented per beat and serves as the remaining-beat count.
  wb_cmd_t             cmd_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_DAT_W-1:0] rdata_q;
  logic                err_q;

  logic cmd_fire, wdata_fire, ack_hit, tmo_hit, rsp_fire, rsp_last;
  logic tmo_clear, tmo_enable, tmo_expired;

  assign cmd_fire   = cmd_ready_o && cmd_valid_i;
  assign wdata_fire = wdata_ready_o && wdata_valid_i;
  assign ack_hit    = (state_q == STROBE) && wbm_ack_i;
  assign tmo_hit    = tmo_expired;
  assign rsp_last   = (cmd_q.len == '0) || err_q;
  assign rsp_fire   = rsp_valid_o && rsp_ready_i;

  assign tmo_clear  = (state_q != STROBE);
  assign tmo_enable = (state_q == STROBE) && !wbm_ack_i;

  npu_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    wbm_cyc_o     = 1'b0;
    wbm_stb_o     = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_last_o    = 1'b0;
    rsp_err_o     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = !wb_rst_i;
        if (cmd_fire) state_d = cmd_we_i ? WDATA : STROBE;
      end
      WDATA: begin
        wdata_ready_o = 1'b1;
        wbm_cyc_o     = 1'b1;
        if (wdata_fire) state_d = STROBE;
      end
      STROBE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        if (ack_hit || tmo_hit) state_d = RESP;
      end
      RESP: begin
        // The bus cycle ends as soon as the final beat is presented.
        wbm_cyc_o   = !rsp_last;
        rsp_valid_o = 1'b1;
        rsp_last_o  = rsp_last;
        rsp_err_o   = err_q;
        if (rsp_fire) state_d = rsp_last ? IDLE : (cmd_q.we ? WDATA : STROBE);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cmd_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cmd_q.we  <= cmd_we_i;
        cmd_q.adr <= cmd_adr_i;
        cmd_q.len <= CMD_LEN_MAX_W'(cmd_len_i);
        cmd_q.sel <= cmd_sel_i;
        dat_q     <= '0;
        rdata_q   <= '0;
        err_q     <= 1'b0;
      end
      if (wdata_fire) dat_q <= wdata_i;
      if (ack_hit) begin
        rdata_q <= cmd_q.we ? '0 : wbm_dat_i;
        err_q   <= 1'b0;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (rsp_fire && !rsp_last) begin
        cmd_q.adr <= cmd_q.adr + WB_ADR_INC;
        cmd_q.len <= cmd_q.len - CMD_LEN_MAX_W'(1);
      end
    end
  end

  assign wbm_we_o   = cmd_q.we;
  assign wbm_adr_o  = cmd_q.adr;
  assign wbm_sel_o  = cmd_q.sel;
  assign wbm_dat_o  = dat_q;
  assign rsp_data_o = rdata_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_npu_wb_master.sv
// Self-checking bench for npu_wb_master: command table, Wishbone slave model, response scoreboard.
module tb_npu_wb_master;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [3:0]  cmd_len_i = '0, cmd_sel_i = '0;
  logic        wdata_valid_i = 1'b0, wdata_ready_o;
  logic [31:0] wdata_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_last_o, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        busy_o;

  npu_wb_master #(.LEN_W(4), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  len;
    logic [3:0]  sel;
    int          wdelay;
    int          swait;
    bit          bp;
    logic [31:0] exp_last_adr;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  typedef struct { logic [31:0] adr; logic we; logic [3:0] sel; logic [31:0] dat; } wb_exp_t;
  typedef struct { logic [31:0] data; logic last; logic err; } rsp_exp_t;

  wb_exp_t  exp_wb_q[$];
  rsp_exp_t exp_rsp_q[$];

  int n_cmp = 0, n_bad = 0;
  int rsp_cnt = 0, ack_cnt = 0, stb_cycles = 0;
  int slv_wait = 0, wcnt = 0;
  bit slv_en = 1'b1, slv_force = 1'b0, bp_mode = 1'b0, burst_active = 1'b0;
  logic [31:0] last_ack_adr = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h3000_0000) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_A5A5) + 32'h11);
  endfunction

  function automatic logic [31:0] wval(input int beat);
    return 32'h1234_5678 + 32'(beat) * 32'h1111_1111;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Slave: acks after slv_wait stb cycles; slv_force injects a stray ack.
  assign wbm_ack_i = (slv_en && wbm_stb_o && (wcnt == slv_wait)) || slv_force;
  assign wbm_dat_i = mem_f(wbm_adr_o);
  always @(posedge wb_clk_i) begin
    if (!wbm_stb_o || wbm_ack_i) wcnt <= 0;
    else                         wcnt <= wcnt + 1;
  end

  initial begin
    forever begin
      @(posedge wb_clk_i); #1;
      rsp_ready_i = bp_mode ? ~rsp_ready_i : 1'b1;
    end
  end

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (wbm_stb_o) begin
        stb_cycles++;
        if (exp_wb_q.size() == 0) chk("unexpected_stb", 32'd1, 32'd0);
        else begin
          chk("wb_adr", wbm_adr_o, exp_wb_q[0].adr);
          chk("wb_we",  32'(wbm_we_o), 32'(exp_wb_q[0].we));
          chk("wb_sel", 32'(wbm_sel_o), 32'(exp_wb_q[0].sel));
          chk("wb_dat", wbm_dat_o, exp_wb_q[0].dat);
          chk("cyc_with_stb", 32'(wbm_cyc_o), 32'd1);
          if (wbm_ack_i) begin
            last_ack_adr = wbm_adr_o;
            void'(exp_wb_q.pop_front());
            ack_cnt++;
          end
        end
      end
      if (burst_active && !(rsp_valid_o && rsp_last_o)) chk("cyc_held", 32'(wbm_cyc_o), 32'd1);
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_rsp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          rsp_exp_t e;
          e = exp_rsp_q.pop_front();
          chk("rsp_data", rsp_data_o, e.data);
          chk("rsp_last", 32'(rsp_last_o), 32'(e.last));
          chk("rsp_err",  32'(rsp_err_o), 32'(e.err));
          if (rsp_last_o) burst_active = 1'b0;
        end
        rsp_cnt++;
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len, input logic [3:0] sel);
    bit ok = 1'b0;
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = len; cmd_sel_i = sel;
    for (int k = 0; k < 50; k++) begin
      @(negedge wb_clk_i);
      if (cmd_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("cmd_handshake_timeout", 32'd0, 32'd1);
    @(posedge wb_clk_i); #1;
    cmd_valid_i = 1'b0;
    burst_active = 1'b1;
  endtask

  task automatic push_exp(input vec_t v, input bit timeout_err);
    for (int i = 0; i <= int'(v.len); i++) begin
      logic [31:0] a;
      a = v.adr + 32'(4 * i);
      exp_wb_q.push_back('{adr: a, we: v.we, sel: v.sel, dat: v.we ? wval(i) : 32'h0});
      if (timeout_err) begin
        exp_rsp_q.push_back('{data: 32'h0, last: 1'b1, err: 1'b1});
        break;
      end
      exp_rsp_q.push_back('{data: v.we ? 32'h0 : mem_f(a), last: (i == int'(v.len)), err: 1'b0});
    end
  endtask

  task automatic wait_rsp(input int target, input string nm);
    for (int k = 0; k < 600; k++) begin
      if (rsp_cnt >= target) break;
      @(posedge wb_clk_i);
    end
    chk(nm, 32'(rsp_cnt), 32'(target));
  endtask

  task automatic run_cmd(input vec_t v);
    int beats, base_rsp, base_stb, lat;
    beats = int'(v.len) + 1;
    slv_wait = v.swait; bp_mode = v.bp;
    push_exp(v, 1'b0);
    base_rsp = rsp_cnt; base_stb = stb_cycles;
    send_cmd(v.we, v.adr, v.len, v.sel);
    if (v.exp_lat != 0) begin
      lat = 0;
      for (int k = 1; k < 40; k++) begin
        @(negedge wb_clk_i);
        if (rsp_valid_o) begin lat = k; break; end
      end
      chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
    end
    if (v.we) begin
      for (int i = 0; i < beats; i++) begin
        bit ok = 1'b0;
        repeat (v.wdelay) @(posedge wb_clk_i);
        #1;
        wdata_valid_i = 1'b1; wdata_i = wval(i);
        for (int k = 0; k < 200; k++) begin
          @(negedge wb_clk_i);
          if (wdata_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wdata_handshake_timeout", 32'd0, 32'd1);
        @(posedge wb_clk_i); #1;
        wdata_valid_i = 1'b0;
      end
    end
    wait_rsp(base_rsp + beats, "rsp_count");
    if (v.exp_stb != 0) chk("stb_cycles", 32'(stb_cycles - base_stb), 32'(v.exp_stb));
    chk("last_beat_adr", last_ack_adr, v.exp_last_adr);
    @(negedge wb_clk_i);
    chk("idle_after_cmd", {30'd0, busy_o, wbm_cyc_o}, 32'd0);
    chk("queues_drained", 32'(exp_wb_q.size() + exp_rsp_q.size()), 32'd0);
    bp_mode = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int base;
    vecs[0] = '{1'b0, 32'h3000_0000, 4'd0,  4'hF, 0, 0, 1'b0, 32'h3000_0000, 2, 1};
    vecs[1] = '{1'b1, 32'h3000_0010, 4'd0,  4'hF, 3, 2, 1'b0, 32'h3000_0010, 0, 3};
    vecs[2] = '{1'b0, 32'h3000_0100, 4'd3,  4'hF, 0, 0, 1'b1, 32'h3000_010C, 0, 4};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 4'd1,  4'h3, 0, 0, 1'b0, 32'h0000_0000, 0, 2};
    vecs[4] = '{1'b1, 32'h3000_0202, 4'd2,  4'hC, 1, 1, 1'b1, 32'h3000_020A, 0, 6};
    vecs[5] = '{1'b0, 32'h3000_0400, 4'd15, 4'hF, 0, 0, 1'b0, 32'h3000_043C, 0, 16};

    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_outputs", {25'd0, cmd_ready_o, wdata_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o, rsp_last_o}, 32'd0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    #1 chk("cmd_ready_after_rst", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // Timeout: slave never acks on a 2-beat read; only one errored beat comes back.
    t = '{1'b0, 32'h3000_0500, 4'd1, 4'hF, 0, 0, 1'b0, 32'h0, 0, 0};
    slv_en = 1'b0;
    push_exp(t, 1'b1);
    base = stb_cycles;
    send_cmd(t.we, t.adr, t.len, t.sel);
    wait_rsp(rsp_cnt + 1, "timeout_rsp_count");
    chk("timeout_stb_cycles", 32'(stb_cycles - base), 32'd8);
    @(negedge wb_clk_i);
    chk("timeout_cyc_dropped", {30'd0, busy_o, wbm_cyc_o}, 32'd0);
    exp_wb_q.delete();
    base = rsp_cnt;
    @(posedge wb_clk_i); #1 slv_force = 1'b1;
    @(posedge wb_clk_i); #1 slv_force = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    chk("late_ack_ignored", {29'd0, rsp_valid_o, busy_o, wbm_stb_o}, 32'd0);
    chk("late_ack_no_rsp", 32'(rsp_cnt), 32'(base));
    slv_en = 1'b1;

    // Reset during the third beat's strobe of a 4-beat read.
    t = '{1'b0, 32'h3000_0800, 4'd3, 4'hF, 0, 3, 1'b0, 32'h0, 0, 0};
    slv_wait = 3;
    push_exp(t, 1'b0);
    base = ack_cnt;
    send_cmd(t.we, t.adr, t.len, t.sel);
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge wb_clk_i);
        if (ack_cnt >= base + 2 && wbm_stb_o) begin ok = 1'b1; break; end
      end
      chk("reach_third_beat", 32'(ok), 32'd1);
    end
    wb_rst_i = 1'b1;
    burst_active = 1'b0;
    #2;
    chk("midrst_outputs", {27'd0, cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, busy_o}, 32'd0);
    exp_wb_q.delete();
    exp_rsp_q.delete();
    @(negedge wb_clk_i); wb_rst_i = 1'b0;
    #1 chk("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    run_cmd(vecs[0]);
    run_cmd(vecs[3]);

    repeat (3) @(posedge wb_clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
